// File: rtl/serial_c_receiver.sv
// Serial C result receiver: deserializes LSB-first frames and queues the words in a FWFT FIFO.
// State table: IDLE | waiting for a first-bit marker ; RECV | collecting the remaining bits of a frame
module serial_c_receiver #(
    parameter int FRAME_BITS = 3,
    parameter int DEPTH      = 4,
    parameter int GAP_MAX    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c_start,
    input  logic                      c_shift,
    input  logic                      c_bit,
    output logic [FRAME_BITS-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      frame_err,
    output logic                      overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GW = $clog2(GAP_MAX + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                state, state_nxt;
    logic [BW-1:0]         bitcnt, bitcnt_nxt;
    logic [GW-1:0]         gapcnt, gapcnt_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic [FRAME_BITS-1:0] start_word, ins_word, push_word;
    logic                  push, err_nxt;

    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  pop, full, do_push;

    always_comb begin
        start_word    = '0;
        start_word[0] = c_bit;
        ins_word         = shreg;
        ins_word[bitcnt] = c_bit;
    end

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        gapcnt_nxt = gapcnt;
        shreg_nxt  = shreg;
        push       = 1'b0;
        push_word  = shreg;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                gapcnt_nxt = '0;
                if (c_shift && c_start) begin
                    if (FRAME_BITS == 1) begin
                        push      = 1'b1;
                        push_word = start_word;
                    end else begin
                        shreg_nxt  = start_word;
                        bitcnt_nxt = BW'(1);
                        state_nxt  = RECV;
                    end
                end else if (c_shift) begin
                    err_nxt = 1'b1;
                end
            end
            RECV: begin
                if (c_shift) begin
                    gapcnt_nxt = '0;
                    if (c_start) begin
                        // Early marker: abandon the partial frame, this bit starts a new one
                        err_nxt    = 1'b1;
                        shreg_nxt  = start_word;
                        bitcnt_nxt = BW'(1);
                    end else if (bitcnt == BW'(FRAME_BITS - 1)) begin
                        push       = 1'b1;
                        push_word  = ins_word;
                        bitcnt_nxt = '0;
                        state_nxt  = IDLE;
                    end else begin
                        shreg_nxt  = ins_word;
                        bitcnt_nxt = bitcnt + BW'(1);
                    end
                end else if (gapcnt == GW'(GAP_MAX - 1)) begin
                    err_nxt    = 1'b1;
                    gapcnt_nxt = '0;
                    bitcnt_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    gapcnt_nxt = gapcnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop     = (level != '0) && out_ready;
    assign full    = (level == LW'(DEPTH));
    // A full FIFO still accepts a word when the head leaves on the same edge
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            gapcnt    <= '0;
            shreg     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            gapcnt    <= gapcnt_nxt;
            shreg     <= shreg_nxt;
            frame_err <= err_nxt;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(pop);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    assign out_valid  = (level != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
endmodule

// File: tb/tb_serial_c_receiver.sv
// Bench for serial_c_receiver: vector table, directed corner sequences and random traffic
// compared every cycle against a queue-based reference model.
module tb_serial_c_receiver;
    localparam int FB    = 3;
    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       c_start = 1'b0, c_shift = 1'b0, c_bit = 1'b0, out_ready = 1'b0;
    logic [2:0] out_data;
    logic       out_valid, frame_err, overflow;
    logic [2:0] fifo_level;

    serial_c_receiver #(.FRAME_BITS(FB), .DEPTH(DEPTH), .GAP_MAX(GAP)) dut (
        .clk(clk), .reset(reset), .c_start(c_start), .c_shift(c_shift), .c_bit(c_bit),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored words, bits of the frame in progress, idle-run length
    logic [2:0] m_q[$];
    bit         m_bits[$];
    bit         m_recv, m_ovf, m_err;
    int         m_gap;

    int         err_seen;
    logic [2:0] popped[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit s, input bit sh, input bit b, input bit r);
        bit         pop, do_push, e;
        logic [2:0] w;
        if (rst) begin
            m_q.delete(); m_bits.delete();
            m_recv = 0; m_gap = 0; m_ovf = 0; m_err = 0;
            return;
        end
        e = 0; do_push = 0; w = '0;
        pop = (m_q.size() != 0) && r;
        if (!m_recv) begin
            m_gap = 0;
            if (sh && s) begin
                m_bits = {b};
                if (FB == 1) do_push = 1; else m_recv = 1;
            end else if (sh) e = 1;
        end else if (sh) begin
            m_gap = 0;
            if (s) begin
                e = 1;
                m_bits = {b};
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == FB) begin do_push = 1; m_recv = 0; end
            end
        end else begin
            m_gap++;
            if (m_gap == GAP) begin e = 1; m_recv = 0; m_gap = 0; end
        end
        if (do_push) for (int i = 0; i < FB; i++) w[i] = m_bits[i];
        if (pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_ovf = 1;
        end
        m_err = e;
    endtask

    task automatic check_model();
        chk("valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
        chk("data", int'(out_data), (m_q.size() != 0) ? int'(m_q[0]) : 0);
        chk("level", int'(fifo_level), m_q.size());
        chk("frame_err", int'(frame_err), int'(m_err));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1ns later
    task automatic apply(input bit rst, input bit s, input bit sh, input bit b, input bit r);
        reset = rst; c_start = s; c_shift = sh; c_bit = b; out_ready = r;
        if (!rst && out_valid && r) popped.push_back(out_data);
        @(posedge clk);
        model_step(rst, s, sh, b, r);
        #1;
        if (frame_err) err_seen++;
        check_model();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, r);
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0);
        err_seen = 0;
        popped.delete();
    endtask

    task automatic send_frame(input logic [2:0] w, input bit r_last);
        apply(0, 1, 1, w[0], 0);
        apply(0, 0, 1, w[1], 0);
        apply(0, 0, 1, w[2], r_last);
    endtask

    typedef struct {
        logic       st, sh, b, rdy;
        logic       v;
        logic [2:0] d;
        int         lvl;
        logic       err, ovf;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1'b0, 1'b0};

        err_seen = 0;
        do_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);

        for (int i = 0; i < 11; i++) begin
            apply(0, tbl[i].st, tbl[i].sh, tbl[i].b, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].v));
            if (tbl[i].v) chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].d));
            chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].lvl);
            chk($sformatf("tbl%0d_err", i), int'(frame_err), int'(tbl[i].err));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
        end

        // Short gaps inside a frame are tolerated
        do_reset();
        apply(0, 1, 1, 0, 0); idle(2, 0);
        apply(0, 0, 1, 1, 0); idle(2, 0);
        apply(0, 0, 1, 1, 0);
        chk("gap2_data", int'(out_data), 6);
        chk("gap2_err", err_seen, 0);

        // Longest tolerated gap: GAP-1 idle cycles
        do_reset();
        apply(0, 1, 1, 0, 0); idle(GAP - 1, 0);
        apply(0, 0, 1, 1, 0); apply(0, 0, 1, 1, 0);
        chk("gap7_level", int'(fifo_level), 1);
        chk("gap7_data", int'(out_data), 6);
        chk("gap7_err", err_seen, 0);

        // Gap of 9 idle cycles kills the frame
        do_reset();
        apply(0, 1, 1, 0, 0); apply(0, 0, 1, 1, 0); idle(9, 0);
        chk("gap9_err", err_seen, 1);
        chk("gap9_level", int'(fifo_level), 0);

        // Overflow: five frames with no consumer
        do_reset();
        for (int w = 1; w <= 5; w++) send_frame(3'(w), 0);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_flag", int'(overflow), 1);
        idle(6, 1);
        chk("ovf_npop", popped.size(), 4);
        for (int i = 0; i < popped.size(); i++) chk($sformatf("ovf_pop%0d", i), int'(popped[i]), i + 1);
        chk("ovf_sticky", int'(overflow), 1);

        // Early start marker restarts the frame
        do_reset();
        apply(0, 1, 1, 1, 0); apply(0, 1, 1, 0, 0);
        apply(0, 0, 1, 1, 0); apply(0, 0, 1, 1, 0);
        chk("restart_err", err_seen, 1);
        chk("restart_data", int'(out_data), 6);
        chk("restart_level", int'(fifo_level), 1);

        // Full FIFO with a pop on the completing edge
        do_reset();
        for (int w = 1; w <= 4; w++) send_frame(3'(w), 0);
        send_frame(3'd5, 1);
        chk("fullpp_ovf", int'(overflow), 0);
        chk("fullpp_level", int'(fifo_level), 4);
        idle(6, 1);
        chk("fullpp_npop", popped.size(), 5);
        for (int i = 0; i < popped.size(); i++) chk($sformatf("fullpp_pop%0d", i), int'(popped[i]), i + 1);

        // Reset in the middle of a frame with words stored
        do_reset();
        send_frame(3'd2, 0); send_frame(3'd7, 0);
        apply(0, 1, 1, 1, 0); apply(0, 0, 1, 0, 0);
        do_reset();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_err", int'(frame_err), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        apply(0, 0, 1, 1, 0); apply(0, 0, 0, 0, 0);
        err_seen = 0;
        send_frame(3'b011, 0);
        idle(3, 1);
        chk("mid_rst_npop", popped.size(), 1);
        if (popped.size() > 0) chk("mid_rst_word", int'(popped[0]), 3);
        chk("mid_rst_err2", err_seen, 0);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int shp;
            shp = ((i / 300) % 3 == 2) ? 10 : 65;
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < shp,
                  1'($urandom),
                  $urandom_range(0, 99) < ((i / 500) % 2 ? 15 : 50));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
